alu_muldiv_unit: RTL and testbench



---
 rtl/alu_muldiv_unit_pkg.sv | 59 +++++
 rtl/alu_muldiv_unit_muldiv.sv | 75 +++++++
 rtl/alu_muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_unit_pkg.sv
// Shared opcode/state encodings and the default outcome of an illegal opcode
// for the ALU + iterative mul/div unit.
package alu_muldiv_unit_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SRL    = 5'd4,
    OP_SRA    = 5'd5,
    OP_XOR    = 5'd6,
    OP_OR     = 5'd7,
    OP_AND    = 5'd8,
    OP_BEQ    = 5'd9,
    OP_BNE    = 5'd10,
    OP_BLT    = 5'd11,
    OP_BGE    = 5'd12,
    OP_SLT    = 5'd13,
    OP_SLTU   = 5'd14,
    OP_BLTU   = 5'd15,
    OP_BGEU   = 5'd16,
    OP_MUL    = 5'd17,
    OP_MULH   = 5'd18,
    OP_MULHSU = 5'd19,
    OP_MULHU  = 5'd20,
    OP_DIV    = 5'd21,
    OP_DIVU   = 5'd22,
    OP_REM    = 5'd23,
    OP_REMU   = 5'd24
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_e;

  // Which slice of the iterative result is returned, after sign correction
  typedef enum logic [1:0] {
    SEL_LO,
    SEL_HI,
    SEL_QUO,
    SEL_REM
  } md_sel_e;

  // An illegal opcode completes in one cycle as result 0, not taken
  localparam logic ILLEGAL_BRANCH = 1'b0;
  localparam logic ILLEGAL_RESULT_BIT = 1'b0;

  function automatic logic is_mul_op(input op_e o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_unit_muldiv.sv
// Unsigned iterative multiply (shift-add) / restoring divide on magnitudes.
// One shared 2*WIDTH work register: {hi, multiplier} or {remainder, quotient}.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] work_reg;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   b_reg;
  logic               div_reg;
  logic               run_reg;
  logic [CW-1:0]      cnt_reg;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  assign mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, b_reg} : '0);
  assign div_shift = work_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, b_reg};

  // A negative trial difference restores the shifted remainder and shifts in 0
  assign work_next = div_reg
    ? {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
       work_reg[WIDTH-2:0], ~div_diff[WIDTH]}
    : {mul_sum, work_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg <= '0;
      b_reg    <= '0;
      div_reg  <= 1'b0;
      run_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else if (abort) begin
      run_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (start) begin
      work_reg <= {{WIDTH{1'b0}}, a_mag};
      b_reg    <= b_mag;
      div_reg  <= is_div;
      run_reg  <= 1'b1;
      cnt_reg  <= '0;
    end else if (run_reg) begin
      work_reg <= work_next;
      if (cnt_reg == CW'(WIDTH - 1)) begin
        run_reg <= 1'b0;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // High during the final iteration; the work register is final after that edge
  assign done      = run_reg && (cnt_reg == CW'(WIDTH - 1));
  assign product   = work_reg;
  assign quotient  = work_reg[WIDTH-1:0];
  assign remainder = work_reg[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_muldiv_unit.sv
// Integer ALU with single-cycle arithmetic/logic/branch ops and a fixed-latency
// iterative multiply/divide path, valid/ready on both sides, tag pass-through.
module alu_muldiv_unit
  import alu_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             branch_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic [TAG_W-1:0] tag_hold_reg;
  md_sel_e          sel_reg;
  logic             neg_reg;

  op_e  op_q;
  logic accept;
  logic op_is_mul;
  logic op_is_div;

  assign op_q      = op_e'(op);
  assign op_is_mul = is_mul_op(op_q);
  assign op_is_div = is_div_op(op_q);
  assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready) && !flush;
  assign accept    = in_valid && in_ready;

  // Compare flags: signed from sign^overflow of rs1-rs2, unsigned from the borrow
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] diff;
  logic             ltu, lts, eq, ovf;
  logic [SHW-1:0]   shamt;

  assign sub_ext = {1'b0, rs1} - {1'b0, rs2};
  assign diff    = sub_ext[WIDTH-1:0];
  assign ltu     = sub_ext[WIDTH];
  assign ovf     = (rs1[WIDTH-1] ^ rs2[WIDTH-1]) & (diff[WIDTH-1] ^ rs1[WIDTH-1]);
  assign lts     = diff[WIDTH-1] ^ ovf;
  assign eq      = (diff == '0);
  assign shamt   = rs2[SHW-1:0];

  logic [WIDTH-1:0] alu_res;
  logic             alu_br;

  always_comb begin
    alu_res = {WIDTH{ILLEGAL_RESULT_BIT}};
    alu_br  = ILLEGAL_BRANCH;
    case (op_q)
      OP_ADD:  alu_res = rs1 + rs2;
      OP_SUB:  alu_res = diff;
      OP_SLL:  alu_res = rs1 << shamt;
      OP_SRL:  alu_res = rs1 >> shamt;
      OP_SRA:  alu_res = $signed(rs1) >>> shamt;
      OP_XOR:  alu_res = rs1 ^ rs2;
      OP_OR:   alu_res = rs1 | rs2;
      OP_AND:  alu_res = rs1 & rs2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lts};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltu};
      OP_BEQ:  alu_br  = eq;
      OP_BNE:  alu_br  = !eq;
      OP_BLT:  alu_br  = lts;
      OP_BGE:  alu_br  = !lts;
      OP_BLTU: alu_br  = ltu;
      OP_BGEU: alu_br  = !ltu;
      default: ;
    endcase
  end

  logic    signed_a, signed_b;
  md_sel_e sel_next;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    sel_next = SEL_LO;
    case (op_q)
      OP_MUL:    begin signed_a = 1'b1; signed_b = 1'b1; sel_next = SEL_LO;  end
      OP_MULH:   begin signed_a = 1'b1; signed_b = 1'b1; sel_next = SEL_HI;  end
      OP_MULHSU: begin signed_a = 1'b1;                  sel_next = SEL_HI;  end
      OP_MULHU:  sel_next = SEL_HI;
      OP_DIV:    begin signed_a = 1'b1; signed_b = 1'b1; sel_next = SEL_QUO; end
      OP_DIVU:   sel_next = SEL_QUO;
      OP_REM:    begin signed_a = 1'b1; signed_b = 1'b1; sel_next = SEL_REM; end
      OP_REMU:   sel_next = SEL_REM;
      default: ;
    endcase
  end

  logic             a_neg, b_neg, neg_next;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = signed_a & rs1[WIDTH-1];
  assign b_neg = signed_b & rs2[WIDTH-1];
  assign a_mag = a_neg ? (~rs1 + 1'b1) : rs1;
  assign b_mag = b_neg ? (~rs2 + 1'b1) : rs2;

  // Divide by zero keeps an unsigned all-ones quotient; remainder follows rs1
  always_comb begin
    case (sel_next)
      SEL_QUO: neg_next = (a_neg ^ b_neg) & (rs2 != '0);
      SEL_REM: neg_next = a_neg;
      default: neg_next = a_neg ^ b_neg;
    endcase
  end

  logic               md_done;
  logic [2*WIDTH-1:0] md_prod;
  logic [WIDTH-1:0]   md_quot, md_rem;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && (op_is_mul || op_is_div)),
    .abort     (flush),
    .is_div    (op_is_div),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .done      (md_done),
    .product   (md_prod),
    .quotient  (md_quot),
    .remainder (md_rem)
  );

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   part, part_fix, fix_val;

  assign prod_fix = neg_reg ? (~md_prod + 1'b1) : md_prod;
  assign part     = (sel_reg == SEL_REM) ? md_rem : md_quot;
  assign part_fix = neg_reg ? (~part + 1'b1) : part;

  always_comb begin
    case (sel_reg)
      SEL_LO:  fix_val = prod_fix[WIDTH-1:0];
      SEL_HI:  fix_val = prod_fix[2*WIDTH-1:WIDTH];
      default: fix_val = part_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      branch_reg    <= 1'b0;
      out_tag_reg   <= '0;
      tag_hold_reg  <= '0;
      sel_reg       <= SEL_LO;
      neg_reg       <= 1'b0;
    end else if (flush) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
          if (accept) begin
            if (op_is_mul || op_is_div) begin
              state_reg    <= op_is_mul ? ST_MUL : ST_DIV;
              tag_hold_reg <= in_tag;
              sel_reg      <= sel_next;
              neg_reg      <= neg_next;
            end else begin
              out_valid_reg <= 1'b1;
              result_reg    <= alu_res;
              branch_reg    <= alu_br;
              out_tag_reg   <= in_tag;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) state_reg <= ST_FIX;
        end
        ST_FIX: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b1;
          result_reg    <= fix_val;
          branch_reg    <= 1'b0;
          out_tag_reg   <= tag_hold_reg;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_reg;
  assign result       = result_reg;
  assign branch_taken = branch_reg;
  assign out_tag      = out_tag_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit (WIDTH=32) with hand-computed
// expected results, latencies, handshake, flush and reset behaviour.
module tb_alu_muldiv_unit;
  import alu_muldiv_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] rs1, rs2;
  logic [3:0]  in_tag, out_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_muldiv_unit #(.WIDTH(32), .OP_W(5), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .in_tag       (in_tag),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .out_tag      (out_tag),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t,
                        input logic [31:0] exp_res, input logic exp_br, input int exp_lat);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    op = o; rs1 = a; rs2 = b; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_branch"}, 64'(branch_taken), 64'(exp_br));
    check({tag, "_tag"}, 64'(out_tag), 64'(t));
    $display("op=%0d tag=%0d rs1=%h rs2=%h -> result=%h branch=%0b latency=%0d",
             o, t, a, b, result, branch_taken, lat);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_branch", 64'(branch_taken), 64'd0);
    check("reset_tag", 64'(out_tag), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    run_op("add",  OP_ADD,  32'd1, 32'd2, 4'd1, 32'd3, 1'b0, 1);
    run_op("sub",  OP_SUB,  32'd5, 32'd7, 4'd2, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("blt",  OP_BLT,  32'h8000_0000, 32'd1, 4'd3, 32'd0, 1'b1, 1);
    run_op("bltu", OP_BLTU, 32'h8000_0000, 32'd1, 4'd4, 32'd0, 1'b0, 1);
    run_op("sll",  OP_SLL,  32'd1, 32'h24, 4'd5, 32'h10, 1'b0, 1);
    run_op("srl",  OP_SRL,  32'h8000_0000, 32'd31, 4'd6, 32'd1, 1'b0, 1);
    run_op("sra",  OP_SRA,  32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000, 1'b0, 1);
    run_op("xor",  OP_XOR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd8, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("or",   OP_OR,   32'h0000_00F0, 32'h0000_0F00, 4'd9, 32'h0000_0FF0, 1'b0, 1);
    run_op("and",  OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 4'd10, 32'h0F00_0F00, 1'b0, 1);
    run_op("beq",  OP_BEQ,  32'd5, 32'd5, 4'd11, 32'd0, 1'b1, 1);
    run_op("bne",  OP_BNE,  32'd5, 32'd5, 4'd12, 32'd0, 1'b0, 1);
    run_op("bge_neg", OP_BGE, 32'hFFFF_FFFF, 32'd1, 4'd13, 32'd0, 1'b0, 1);
    run_op("bge_ovf", OP_BGE, 32'h7FFF_FFFF, 32'h8000_0000, 4'd14, 32'd0, 1'b1, 1);
    run_op("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 4'd15, 32'd1, 1'b0, 1);
    run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b0, 1);
    run_op("bgeu", OP_BGEU, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd0, 1'b1, 1);
    run_op("illegal3", 5'd3, 32'd9, 32'd9, 4'd2, 32'd0, 1'b0, 1);

    // Multiply / divide: fixed latency WIDTH+2
    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 4'd3, 32'h4000_0000, 1'b0, 34);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 4'd4, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'd1, 1'b0, 34);
    run_op("div_by0", OP_DIV, 32'd7, 32'd0, 4'd7, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("rem_by0", OP_REM, 32'd7, 32'd0, 4'd8, 32'd7, 1'b0, 34);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'h8000_0000, 1'b0, 34);
    run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 4'd10, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd11, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("divu",    OP_DIVU, 32'd100, 32'd7, 4'd12, 32'd14, 1'b0, 34);
    run_op("remu",    OP_REMU, 32'd100, 32'd7, 4'd13, 32'd2, 1'b0, 34);

    // Back-to-back single-cycle ops, one per cycle
    @(posedge clk); #1;
    op = OP_ADD; rs1 = 32'd10; rs2 = 32'd20; in_tag = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_result", 64'(result), 64'd30);
    check("b2b_ready", 64'(in_ready), 64'd1);
    op = OP_SUB; rs1 = 32'd10; rs2 = 32'd3; in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_result", 64'(result), 64'd7);
    check("b2b_second_tag", 64'(out_tag), 64'd2);
    $display("back-to-back ADD/SUB -> result=%h tag=%0d", result, out_tag);

    // Output stall: result held and in_ready low while out_ready is low
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op("stall_add", OP_ADD, 32'd1, 32'd2, 4'd3, 32'd3, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_result", 64'(result), 64'd3);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("stall_drained", 64'(out_valid), 64'd0);
    $display("stall ADD held 5 cycles -> result=%h", result);

    // Flush in the middle of a divide
    op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; in_tag = 4'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_busy_before", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("flush_no_late_valid", 64'(out_valid), 64'd0);
    end
    $display("flush DIVU after 10 cycles -> busy=%0b out_valid=%0b", busy, out_valid);
    run_op("post_flush_add", OP_ADD, 32'h0000_1000, 32'h0000_0234, 4'hA, 32'h0000_1234, 1'b0, 1);

    // Asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5; in_tag = 4'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_branch", 64'(branch_taken), 64'd0);
    check("arst_tag", 64'(out_tag), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    $display("async reset mid-MUL -> result=%h busy=%0b", result, busy);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("illegal25", 5'd25, 32'hDEAD_BEEF, 32'd1, 4'd5, 32'd0, 1'b0, 1);
    run_op("mul_after_rst", OP_MUL, 32'd3, 32'd5, 4'd7, 32'd15, 1'b0, 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
